// File: rtl/alu_shift_pkg.sv
// Shared encodings for the multi-cycle ALU shifter:
// shift modes and controller states.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    MODE_LSL = 3'b000,
    MODE_LSR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step: next register value
// and the bit that leaves the register.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_mode,
  input  logic             i_serial,
  input  logic             i_out,
  output logic [WIDTH-1:0] o_data,
  output logic             o_out
);

  // select the step result by mode; reserved modes hold
  always_comb begin
    o_data = i_data;
    o_out  = i_out;
    case (i_mode)
      MODE_LSL: begin
        o_data = {i_data[WIDTH-2:0], i_serial};
        o_out  = i_data[WIDTH-1];
      end
      MODE_LSR: begin
        o_data = {i_serial, i_data[WIDTH-1:1]};
        o_out  = i_data[0];
      end
      MODE_ASR: begin
        o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
        o_out  = i_data[0];
      end
      MODE_ROL: begin
        o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
        o_out  = i_data[WIDTH-1];
      end
      MODE_ROR: begin
        o_data = {i_data[0], i_data[WIDTH-1:1]};
        o_out  = i_data[0];
      end
      default: begin
        o_data = i_data;
        o_out  = i_out;
      end
    endcase
  end

endmodule

// File: rtl/multi_shift_rgst.sv
// Multi-cycle shift register with start/done handshake,
// one bit position per clock, last shifted bit kept as flag.
module multi_shift_rgst
  import alu_shift_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_enable,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               shift_out,
  output logic               busy,
  output logic               done
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [2:0]           r_mode;
  logic [WIDTH-1:0]     r_data;
  logic                 r_sout;
  logic [WIDTH-1:0]     w_step_data;
  logic                 w_step_out;
  logic                 w_go;

  // a load in the same cycle swallows the start request
  assign w_go = (r_state == ST_IDLE) && !load_enable && start;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_data   (r_data),
    .i_mode   (r_mode),
    .i_serial (serial_in),
    .i_out    (r_sout),
    .o_data   (w_step_data),
    .o_out    (w_step_out)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if (shamt == '0) w_state_nxt = ST_DONE;
          else             w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == SHAMT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // datapath: load, operation latch, per-step update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 3'b000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_enable) begin
            r_data <= data_in;
          end else if (start) begin
            r_mode <= mode;
            r_cnt  <= shamt;
          end
        end
        ST_SHIFT: begin
          r_data <= w_step_data;
          r_sout <= w_step_out;
          r_cnt  <= r_cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_out  = r_data;
  assign shift_out = r_sout;

endmodule

// File: tb/tb_multi_shift_rgst.sv
// Scoreboard bench for multi_shift_rgst at WIDTH=8:
// expected results queued at start, checked on done.
module tb_multi_shift_rgst;

  localparam int W  = 8;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_enable;
  logic [W-1:0]  data_in;
  logic          start;
  logic [2:0]    mode;
  logic [SW-1:0] shamt;
  logic          serial_in;
  logic [W-1:0]  data_out;
  logic          shift_out;
  logic          busy;
  logic          done;

  int           n_chk  = 0;
  int           n_fail = 0;
  exp_t         exp_q[$];
  logic [W-1:0] m_data;
  logic         m_sout;

  multi_shift_rgst #(
    .WIDTH   (W),
    .SHAMT_W (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_enable (load_enable),
    .data_in     (data_in),
    .start       (start),
    .mode        (mode),
    .shamt       (shamt),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .shift_out   (shift_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] md, input logic sin,
                       inout logic [W-1:0] d, inout logic s);
    case (md)
      3'd0: begin s = d[7]; d = (d << 1) | W'(sin); end
      3'd1: begin s = d[0]; d = (d >> 1) | (W'(sin) << 7); end
      3'd2: begin s = d[0]; d = W'($signed(d) >>> 1); end
      3'd3: begin s = d[7]; d = {d[6:0], d[7]}; end
      3'd4: begin s = d[0]; d = {d[0], d[7:1]}; end
      default: ;
    endcase
  endtask

  // scoreboard: every done pulse consumes one expectation
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(data_out), 32'(e.d));
        check("sb_sout", 32'(shift_out), 32'(e.s));
      end
    end
  end

  task automatic do_load(input logic [W-1:0] v);
    @(negedge clk);
    load_enable = 1'b1;
    data_in     = v;
    @(posedge clk);
    #1;
    load_enable = 1'b0;
    check("load", 32'(data_out), 32'(v));
    m_data = v;
  endtask

  task automatic run_op(input logic [2:0] md, input int n,
                        input logic sin, input bit poke);
    logic [W-1:0] d;
    logic         s;
    int           k;
    exp_t         e;
    d = m_data;
    s = m_sout;
    for (int i = 0; i < n; i++) model(md, sin, d, s);
    m_data = d;
    m_sout = s;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
    @(negedge clk);
    mode      = md;
    shamt     = SW'(n);
    serial_in = sin;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 3'b111;
    shamt = SW'($urandom_range(0, 15));
    k = 0;
    check("busy_e0", 32'(busy), 32'(n != 0));
    check("done_e0", 32'(done), 32'(n == 0));
    while (!done && k < n + 4) begin
      if (poke && k == 0) begin
        load_enable = 1'b1;
        data_in     = 8'hFF;
        start       = 1'b1;
      end
      @(posedge clk);
      #1;
      load_enable = 1'b0;
      start       = 1'b0;
      k++;
      if (!done) check("busy_shift", 32'(busy), 1);
    end
    check("latency", k, n);
    check("busy_end", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("done_fall", 32'(done), 0);
  endtask

  initial begin
    reset       = 1'b1;
    load_enable = 1'b0;
    data_in     = '0;
    start       = 1'b0;
    mode        = 3'b000;
    shamt       = '0;
    serial_in   = 1'b0;
    m_data      = '0;
    m_sout      = 1'b0;
    #12;
    check("rst_data", 32'(data_out), 0);
    check("rst_sout", 32'(shift_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    do_load(8'hB2);
    run_op(3'd0, 3, 1'b1, 1'b0);
    check("tp_lsl", 32'(data_out), 32'h97);
    check("tp_lsl_so", 32'(shift_out), 1);

    do_load(8'hB2);
    run_op(3'd2, 2, 1'b0, 1'b0);
    check("tp_asr", 32'(data_out), 32'hEC);

    do_load(8'hB2);
    run_op(3'd4, 8, 1'b0, 1'b0);
    check("tp_ror8", 32'(data_out), 32'hB2);
    run_op(3'd3, 1, 1'b0, 1'b0);
    check("tp_rol1", 32'(data_out), 32'h65);
    check("tp_rol1_so", 32'(shift_out), 1);

    run_op(3'd1, 0, 1'b1, 1'b0);
    check("tp_zero", 32'(data_out), 32'h65);

    do_load(8'h5A);
    run_op(3'd1, 4, 1'b0, 1'b1);
    check("tp_poke", 32'(data_out), 32'h05);

    @(negedge clk);
    load_enable = 1'b1;
    start       = 1'b1;
    data_in     = 8'h3C;
    mode        = 3'd0;
    shamt       = 4'd2;
    @(posedge clk);
    #1;
    load_enable = 1'b0;
    start       = 1'b0;
    m_data      = 8'h3C;
    check("ld_st_data", 32'(data_out), 32'h3C);
    for (int i = 0; i < 3; i++) begin
      check("ld_st_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
    end

    run_op(3'd5, 3, 1'b1, 1'b0);
    check("hold", 32'(data_out), 32'h3C);

    run_op(3'd0, 12, 1'b0, 1'b0);
    check("lsl12", 32'(data_out), 0);

    do_load(8'hC3);
    @(negedge clk);
    mode  = 3'd3;
    shamt = 4'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_data", 32'(data_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_sout", 32'(shift_out), 0);
    @(posedge clk);
    #1;
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    reset  = 1'b0;
    m_data = '0;
    m_sout = 1'b0;

    do_load(8'h81);
    run_op(3'd1, 2, 1'b0, 1'b0);
    check("post_rst", 32'(data_out), 32'h20);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
